psum_acc: RTL

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_acc_pkg.sv | 21 ++
 rtl/psum_acc_if.sv | 32 +++
 rtl/psum_post.sv | 41 ++++
 rtl/psum_acc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared sizing constants, the controller state enum and the
// lane sign-extension helper for the partial-sum accumulator.
package psum_acc_pkg;

    localparam int LANES      = 36;
    localparam int PSUM_W     = 24;
    localparam int ACC_W      = 28;
    localparam int OUT_W      = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Widen one signed Psum lane to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] v);
        return {{(ACC_W-PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/psum_acc_if.sv
// psum_acc_if: data-path bundle between the adder tree, the accumulator and
// the consumer.
//   Psum_valid / Psum     : partial-sum beat from the adder tree (no backpressure)
//   out_valid / out_ready : output tile handshake
//   out_data              : 36 x 16-bit output tile
// master = producer/consumer side (testbench), slave = psum_acc.
interface psum_acc_if;
    import psum_acc_pkg::*;

    logic                      Psum_valid;
    logic [LANES*PSUM_W-1:0]   Psum;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    out_data;

    modport master (
        output Psum_valid,
        output Psum,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  Psum_valid,
        input  Psum,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/psum_post.sv
// psum_post: per-lane post-processing of a completed accumulator value.
//   sum_i   : signed accumulator value (acc + final Psum beat)
//   relu_i  : clamp negative values to zero before shifting
//   shift_i : arithmetic right-shift amount
//   lane_o  : result saturated to signed 16 bits
module psum_post
    import psum_acc_pkg::*;
(
    input  logic signed [ACC_W-1:0] sum_i,
    input  logic                    relu_i,
    input  logic [3:0]              shift_i,
    output logic [OUT_W-1:0]        lane_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    logic signed [ACC_W-1:0] relu_s;
    logic signed [ACC_W-1:0] shifted_s;

    // ReLU, arithmetic shift, then clamp into the 16-bit output range.
    always_comb begin
        relu_s    = sum_i;
        shifted_s = '0;
        lane_o    = '0;
        if (relu_i && sum_i[ACC_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = sum_i;
        end
        shifted_s = relu_s >>> shift_i;
        if (shifted_s > SAT_MAX) begin
            lane_o = 16'h7FFF;
        end else if (shifted_s < SAT_MIN) begin
            lane_o = 16'h8000;
        end else begin
            lane_o = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/psum_acc.sv
// psum_acc: accumulates cfg_rounds+1 Psum beats per output tile over 36
// lanes, post-processes each finished tile (ReLU / shift / saturate) and
// queues it in a 2-entry output FIFO. A job runs cfg_tiles+1 tiles.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg_start       : starts a job (IDLE only), latching cfg_rounds/tiles/shift/relu
//   bus (slave)     : Psum_valid/Psum in, out_valid/out_ready/out_data tile handshake
//   busy            : job in progress
//   done            : one-cycle pulse after the final tile of a job is pushed
//   err_ovf         : sticky, a finished tile was dropped on a full FIFO
module psum_acc
    import psum_acc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [3:0]  cfg_rounds,
    input  logic [7:0]  cfg_tiles,
    input  logic [3:0]  cfg_shift,
    input  logic        cfg_relu,
    psum_acc_if.slave   bus,
    output logic        busy,
    output logic        done,
    output logic        err_ovf
);

    localparam int OW = LANES * OUT_W;

    state_e                  state_q, state_d;
    logic [3:0]              rounds_q, rounds_d;
    logic [7:0]              tiles_q, tiles_d;
    logic [3:0]              shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [3:0]              beat_q, beat_d;
    logic [7:0]              tile_q, tile_d;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic signed [ACC_W-1:0] sum_s [LANES];
    logic [OW-1:0]           fifo_q [FIFO_DEPTH];
    logic [OW-1:0]           fifo_d [FIFO_DEPTH];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic                    done_q, done_d;
    logic                    err_ovf_q, err_ovf_d;

    logic                    start_s;
    logic                    complete_s;
    logic                    last_s;
    logic                    pop_s;
    logic                    push_ok_s;
    logic                    drop_s;
    logic [OW-1:0]           tile_data_s;

    assign start_s    = (state_q == ST_IDLE) && cfg_start;
    assign complete_s = (state_q == ST_ACC) && bus.Psum_valid && (beat_q == rounds_q);
    assign last_s     = (tile_q == tiles_q);

    // Running sum including the current beat; also feeds post-processing on the final beat.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sum_s[k] = acc_q[k] + sext_psum(bus.Psum[k*PSUM_W +: PSUM_W]);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        psum_post u_post (
            .sum_i   (sum_s[k]),
            .relu_i  (relu_q),
            .shift_i (shift_q),
            .lane_o  (tile_data_s[k*OUT_W +: OUT_W])
        );
    end

    // Controller next state: config latch, beat/tile counting, accumulator update.
    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        tiles_d  = tiles_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        beat_d   = beat_q;
        tile_d   = tile_q;
        done_d   = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            acc_d[k] = acc_q[k];
        end
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    rounds_d = cfg_rounds;
                    tiles_d  = cfg_tiles;
                    shift_d  = cfg_shift;
                    relu_d   = cfg_relu;
                    beat_d   = 4'd0;
                    tile_d   = 8'd0;
                    for (int k = 0; k < LANES; k++) begin
                        acc_d[k] = '0;
                    end
                    state_d  = ST_ACC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (bus.Psum_valid) begin
                    if (complete_s) begin
                        // Tile finished: the sum goes to the FIFO, not back into the accumulators.
                        for (int k = 0; k < LANES; k++) begin
                            acc_d[k] = '0;
                        end
                        beat_d = 4'd0;
                        tile_d = tile_q + 8'd1;
                        if (last_s) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end else begin
                        for (int k = 0; k < LANES; k++) begin
                            acc_d[k] = sum_s[k];
                        end
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output FIFO: a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        pop_s     = (count_q != 2'd0) && bus.out_ready;
        push_ok_s = complete_s && ((count_q < 2'(FIFO_DEPTH)) || pop_s);
        drop_s    = complete_s && !push_ok_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (push_ok_s) begin
            fifo_d[wr_ptr_q] = tile_data_s;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d         = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok_s} - {1'b0, pop_s};
    end

    // Sticky overflow flag, cleared only when a new job is accepted.
    always_comb begin
        if (start_s) begin
            err_ovf_d = 1'b0;
        end else if (drop_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rounds_q  <= 4'd0;
            tiles_q   <= 8'd0;
            shift_q   <= 4'd0;
            relu_q    <= 1'b0;
            beat_q    <= 4'd0;
            tile_q    <= 8'd0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rounds_q  <= rounds_d;
            tiles_q   <= tiles_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            beat_q    <= beat_d;
            tile_q    <= tile_d;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= acc_d[k];
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = fifo_q[rd_ptr_q];
    assign busy          = (state_q == ST_ACC);
    assign done          = done_q;
    assign err_ovf       = err_ovf_q;

endmodule
